// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : Architectural register file with per-register rename tags.
//                Holds committed values written by the ROB commit port,
//                records the ROB position that will produce each register
//                when the Decoder issues, and answers two source-operand
//                queries with either a value or the producing ROB position.
//                A rollback drops every outstanding rename.
//
//  Ports
//    clk             : clock, state updates on rising edge
//    rst             : asynchronous active-low reset
//    rdy             : global ready, low freezes all state
//    rollback        : misprediction flush, clears every busy flag
//    reg_write       : commit of a register result this cycle
//    reg_rd          : committed destination register
//    reg_val         : committed value
//    commit_rob_pos  : ROB position of the committing instruction
//    issue           : Decoder renames issue_rd this cycle
//    issue_rd        : destination being renamed
//    issue_rob_pos   : ROB position allocated to the new producer
//    rs1 / rs2       : source register indices
//    rs1_val/rs2_val : operand value, meaningful when not busy
//    rs1_busy/rs2_busy : 1 = value still pending in the ROB
//    rs1_rob_pos/rs2_rob_pos : producing ROB position, meaningful when busy
//
//  Revision    : 1.0 - initial release
// ============================================================================

module reg_file #(
    parameter int REG_NUM      = 32,
    parameter int REG_POS_BITS = 5,
    parameter int ROB_POS_BITS = 4,
    parameter int DATA_BITS    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,

    input  logic                    reg_write,
    input  logic [REG_POS_BITS-1:0] reg_rd,
    input  logic [DATA_BITS-1:0]    reg_val,
    input  logic [ROB_POS_BITS-1:0] commit_rob_pos,

    input  logic                    issue,
    input  logic [REG_POS_BITS-1:0] issue_rd,
    input  logic [ROB_POS_BITS-1:0] issue_rob_pos,

    input  logic [REG_POS_BITS-1:0] rs1,
    output logic [DATA_BITS-1:0]    rs1_val,
    output logic                    rs1_busy,
    output logic [ROB_POS_BITS-1:0] rs1_rob_pos,

    input  logic [REG_POS_BITS-1:0] rs2,
    output logic [DATA_BITS-1:0]    rs2_val,
    output logic                    rs2_busy,
    output logic [ROB_POS_BITS-1:0] rs2_rob_pos
);

    localparam logic [REG_NUM-1:0]      c_sel_base = {{(REG_NUM-1){1'b0}}, 1'b1};
    localparam logic [REG_POS_BITS-1:0] c_x0       = '0;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0]    r_val [REG_NUM];
    logic [ROB_POS_BITS-1:0] r_tag [REG_NUM];
    logic [REG_NUM-1:0]      r_busy;

    // ------------------------------------------------------------------
    // Qualified write strobes. x0 is excluded here so the update loop
    // never touches entry 0 after reset, keeping it permanently zero.
    // ------------------------------------------------------------------
    logic               w_commit_en;
    logic               w_issue_en;
    logic               w_flush;
    logic [REG_NUM-1:0] w_commit_sel;
    logic [REG_NUM-1:0] w_issue_sel;

    assign w_commit_en  = rdy && reg_write && (reg_rd != c_x0);
    assign w_flush      = rdy && rollback;
    // A rename issued in the flush cycle belongs to the squashed path.
    assign w_issue_en   = rdy && issue && (issue_rd != c_x0) && !rollback;

    assign w_commit_sel = w_commit_en ? (c_sel_base << reg_rd)   : '0;
    assign w_issue_sel  = w_issue_en  ? (c_sel_base << issue_rd) : '0;

    // ------------------------------------------------------------------
    // State update
    //   - a commit always writes the value, even when the tag is stale
    //     or a rollback is in progress (the instruction is architectural)
    //   - busy is cleared by a commit only when the committing ROB slot is
    //     still the latest producer; a same-cycle rename takes priority
    //     because it describes a younger producer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
            r_busy <= '0;
        end else if (rdy) begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (w_commit_sel[i]) begin
                    r_val[i] <= reg_val;
                end

                if (w_flush) begin
                    r_busy[i] <= 1'b0;
                end else if (w_issue_sel[i]) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= issue_rob_pos;
                end else if (w_commit_sel[i] && (r_tag[i] == commit_rob_pos)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand queries
    // A commit landing on the register's current producer is forwarded so
    // the Decoder does not wait a cycle for a value that is already here.
    // Same-cycle issue is deliberately ignored: sources are read before the
    // instruction renames its own destination.
    // ------------------------------------------------------------------
    logic w_rs1_fwd;
    logic w_rs2_fwd;

    assign w_rs1_fwd = w_commit_en && (reg_rd == rs1) && r_busy[rs1]
                       && (r_tag[rs1] == commit_rob_pos);
    assign w_rs2_fwd = w_commit_en && (reg_rd == rs2) && r_busy[rs2]
                       && (r_tag[rs2] == commit_rob_pos);

    always_comb begin
        rs1_val     = r_val[rs1];
        rs1_busy    = r_busy[rs1];
        rs1_rob_pos = r_tag[rs1];
        if (rs1 == c_x0) begin
            rs1_val     = '0;
            rs1_busy    = 1'b0;
            rs1_rob_pos = '0;
        end else if (w_rs1_fwd) begin
            rs1_val  = reg_val;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_val     = r_val[rs2];
        rs2_busy    = r_busy[rs2];
        rs2_rob_pos = r_tag[rs2];
        if (rs2 == c_x0) begin
            rs2_val     = '0;
            rs2_busy    = 1'b0;
            rs2_rob_pos = '0;
        end else if (w_rs2_fwd) begin
            rs2_val  = reg_val;
            rs2_busy = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Scoreboard bench for reg_file. A stimulus process applies
//                one set of inputs per cycle and queues the query results a
//                behavioural register-file model predicts; a monitor pops
//                and compares them while the inputs are stable.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_reg_file;

    localparam int REG_NUM = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        rollback = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  reg_rd = '0;
    logic [31:0] reg_val = '0;
    logic [3:0]  commit_rob_pos = '0;
    logic        issue = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [3:0]  issue_rob_pos = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] rs1_val;
    logic        rs1_busy;
    logic [3:0]  rs1_rob_pos;
    logic [31:0] rs2_val;
    logic        rs2_busy;
    logic [3:0]  rs2_rob_pos;

    reg_file #(
        .REG_NUM      (32),
        .REG_POS_BITS (5),
        .ROB_POS_BITS (4),
        .DATA_BITS    (32)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .reg_write      (reg_write),
        .reg_rd         (reg_rd),
        .reg_val        (reg_val),
        .commit_rob_pos (commit_rob_pos),
        .issue          (issue),
        .issue_rd       (issue_rd),
        .issue_rob_pos  (issue_rob_pos),
        .rs1            (rs1),
        .rs1_val        (rs1_val),
        .rs1_busy       (rs1_busy),
        .rs1_rob_pos    (rs1_rob_pos),
        .rs2            (rs2),
        .rs2_val        (rs2_val),
        .rs2_busy       (rs2_busy),
        .rs2_rob_pos    (rs2_rob_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rollback;
        logic        reg_write;
        logic [4:0]  reg_rd;
        logic [31:0] reg_val;
        logic [3:0]  cpos;
        logic        issue;
        logic [4:0]  issue_rd;
        logic [3:0]  ipos;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } stim_t;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] v1;
        logic        b1;
        logic [3:0]  p1;
        logic [31:0] v2;
        logic        b2;
        logic [3:0]  p2;
    } exp_t;

    // Reference model: committed value, pending flag and producer per register
    logic [31:0] m_val  [REG_NUM];
    logic        m_busy [REG_NUM];
    logic [3:0]  m_tag  [REG_NUM];

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 1'b0;

    function automatic void model_reset();
        for (int i = 0; i < REG_NUM; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endfunction

    function automatic void model_query(input stim_t s, input logic [4:0] rs,
                                        output logic [31:0] v, output logic b,
                                        output logic [3:0] p);
        if (rs == 5'd0) begin
            v = '0; b = 1'b0; p = '0;
        end else if (s.rdy && s.reg_write && s.reg_rd == rs && m_busy[rs]
                     && m_tag[rs] == s.cpos) begin
            v = s.reg_val; b = 1'b0; p = m_tag[rs];
        end else begin
            v = m_val[rs]; b = m_busy[rs]; p = m_tag[rs];
        end
    endfunction

    function automatic void model_edge(input stim_t s);
        if (s.reg_write && s.reg_rd != 5'd0)
            m_val[s.reg_rd] = s.reg_val;
        if (s.rollback) begin
            for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
        end else begin
            if (s.reg_write && s.reg_rd != 5'd0 && m_tag[s.reg_rd] == s.cpos
                && !(s.issue && s.issue_rd == s.reg_rd))
                m_busy[s.reg_rd] = 1'b0;
            if (s.issue && s.issue_rd != 5'd0) begin
                m_busy[s.issue_rd] = 1'b1;
                m_tag[s.issue_rd]  = s.ipos;
            end
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.rdy = 1'b1; s.rollback = 1'b0;
        s.reg_write = 1'b0; s.reg_rd = '0; s.reg_val = '0; s.cpos = '0;
        s.issue = 1'b0; s.issue_rd = '0; s.ipos = '0;
        s.rs1 = '0; s.rs2 = '0;
        return s;
    endfunction

    function automatic logic [4:0] pick_reg();
        // Bias toward a small set so renames, commits and reads collide often
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle();
        s.rdy       = ($urandom_range(0, 9) != 0);
        s.rollback  = ($urandom_range(0, 24) == 0);
        s.reg_write = 1'($urandom_range(0, 1));
        s.reg_rd    = pick_reg();
        s.reg_val   = $urandom();
        s.cpos      = ($urandom_range(0, 3) != 0) ? m_tag[s.reg_rd] : 4'($urandom_range(0, 15));
        s.issue     = 1'($urandom_range(0, 1));
        s.issue_rd  = ($urandom_range(0, 4) == 0) ? s.reg_rd : pick_reg();
        s.ipos      = 4'($urandom_range(0, 15));
        s.rs1       = ($urandom_range(0, 2) == 0) ? s.reg_rd : pick_reg();
        s.rs2       = ($urandom_range(0, 3) == 0) ? s.issue_rd : pick_reg();
        return s;
    endfunction

    // Apply one cycle of inputs, queue the predicted answers, then advance
    // the model to the state the coming rising edge should produce.
    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst            = s.rst_n;
        rdy            = s.rdy;
        rollback       = s.rollback;
        reg_write      = s.reg_write;
        reg_rd         = s.reg_rd;
        reg_val        = s.reg_val;
        commit_rob_pos = s.cpos;
        issue          = s.issue;
        issue_rd       = s.issue_rd;
        issue_rob_pos  = s.ipos;
        rs1            = s.rs1;
        rs2            = s.rs2;
        if (!s.rst_n) model_reset();
        e.rs1 = s.rs1;
        e.rs2 = s.rs2;
        model_query(s, s.rs1, e.v1, e.b1, e.p1);
        model_query(s, s.rs2, e.v2, e.b2, e.p2);
        sb.push_back(e);
        if (s.rst_n && s.rdy) model_edge(s);
    endtask

    task automatic check_port(input string name, input logic [4:0] rs,
                              input logic [31:0] av, input logic ab, input logic [3:0] ap,
                              input logic [31:0] ev, input logic eb, input logic [3:0] ep);
        n_tests++;
        if (av !== ev || ab !== eb || ((eb || rs == 5'd0) && ap !== ep)) begin
            n_fail++;
            $display("FAIL %s rs=%0d actual val=%h busy=%b pos=%0d required val=%h busy=%b pos=%0d",
                     name, rs, av, ab, ap, ev, eb, ep);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-low-phase while the
    // inputs applied at the falling edge are stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check_port("rs1_query", e.rs1, rs1_val, rs1_busy, rs1_rob_pos, e.v1, e.b1, e.p1);
                check_port("rs2_query", e.rs2, rs2_val, rs2_busy, rs2_rob_pos, e.v2, e.b2, e.p2);
            end
        end
    end

    initial begin
        stim_t s;
        model_reset();
        #1 rst = 1'b0;

        // Reset, then read x5 and x0
        s = idle(); s.rst_n = 1'b0; s.rs1 = 5'd5; s.rs2 = 5'd0;
        step(s); step(s);
        s.rst_n = 1'b1; step(s); step(s);

        // Rename then commit with forwarding
        s = idle(); s.issue = 1'b1; s.issue_rd = 5'd3; s.ipos = 4'd7; s.rs1 = 5'd3; step(s);
        s = idle(); s.rs1 = 5'd3; step(s);
        s = idle(); s.reg_write = 1'b1; s.reg_rd = 5'd3; s.cpos = 4'd7;
        s.reg_val = 32'hDEADBEEF; s.rs1 = 5'd3; s.rs2 = 5'd3; step(s);
        s = idle(); s.rs1 = 5'd3; step(s);

        // Stale commit
        s = idle(); s.issue = 1'b1; s.issue_rd = 5'd4; s.ipos = 4'd2; step(s);
        s = idle(); s.issue = 1'b1; s.issue_rd = 5'd4; s.ipos = 4'd9; step(s);
        s = idle(); s.reg_write = 1'b1; s.reg_rd = 5'd4; s.cpos = 4'd2;
        s.reg_val = 32'h11; s.rs1 = 5'd4; step(s);
        s = idle(); s.rs1 = 5'd4; step(s);
        s = idle(); s.reg_write = 1'b1; s.reg_rd = 5'd4; s.cpos = 4'd9;
        s.reg_val = 32'h22; s.rs1 = 5'd4; step(s);
        s = idle(); s.rs1 = 5'd4; step(s);

        // Same-cycle commit and issue
        s = idle(); s.issue = 1'b1; s.issue_rd = 5'd6; s.ipos = 4'd1; step(s);
        s = idle(); s.reg_write = 1'b1; s.reg_rd = 5'd6; s.cpos = 4'd1; s.reg_val = 32'h55;
        s.issue = 1'b1; s.issue_rd = 5'd6; s.ipos = 4'd3; s.rs1 = 5'd6; step(s);
        s = idle(); s.rs1 = 5'd6; step(s);

        // Rollback with concurrent issue and commit
        s = idle(); s.issue = 1'b1; s.issue_rd = 5'd1;  s.ipos = 4'd10; step(s);
        s = idle(); s.issue = 1'b1; s.issue_rd = 5'd2;  s.ipos = 4'd11; step(s);
        s = idle(); s.issue = 1'b1; s.issue_rd = 5'd31; s.ipos = 4'd12; s.rs1 = 5'd31; step(s);
        s = idle(); s.rollback = 1'b1; s.issue = 1'b1; s.issue_rd = 5'd8; s.ipos = 4'd5;
        s.reg_write = 1'b1; s.reg_rd = 5'd2; s.cpos = 4'd0; s.reg_val = 32'h77;
        s.rs1 = 5'd1; s.rs2 = 5'd2; step(s);
        s = idle(); s.rs1 = 5'd2; s.rs2 = 5'd8; step(s);
        s = idle(); s.rs1 = 5'd1; s.rs2 = 5'd31; step(s);

        // x0 discard and rdy freeze
        s = idle(); s.issue = 1'b1; s.issue_rd = 5'd0; s.ipos = 4'd4;
        s.reg_write = 1'b1; s.reg_rd = 5'd0; s.reg_val = 32'hFF; s.rs1 = 5'd0; step(s);
        s = idle(); s.rs1 = 5'd0; step(s);
        s = idle(); s.rdy = 1'b0; s.issue = 1'b1; s.issue_rd = 5'd10; s.ipos = 4'd6; s.rs1 = 5'd10; step(s);
        s = idle(); s.rs1 = 5'd10; step(s);

        // Randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 3000; n++) begin
            s = rand_stim();
            if (n >= 1500 && n < 1503) s.rst_n = 1'b0;
            step(s);
        end

        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        repeat (2) @(negedge clk);
        #4;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d entries left required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=stimulus incomplete required=complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
